// File: rtl/axil_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into an AW/W/B or AR/R
// exchange, guards it with a response timeout and returns one response beat.
module axil_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    core_clk,
    input  logic                    core_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        tmo_cnt_q;
    logic [CNT_W-1:0]        tmo_cnt_d;
    logic                    tmo_expired_s;
    logic                    abort_s;
    logic                    cmd_ready_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;
    logic                    rsp_timeout_q;

    // Timeout detection; a response arriving on the expiry cycle wins over the abort.
    always_comb begin
        tmo_cnt_d     = tmo_cnt_q + CNT_W'(1);
        tmo_expired_s = (tmo_cnt_q == TMO_LAST);
        abort_s       = 1'b0;
        case (state_q)
            WR:      abort_s = tmo_expired_s;
            WR_RESP: abort_s = tmo_expired_s && !m_axil_bvalid;
            RD_ADDR: abort_s = tmo_expired_s;
            RD_DATA: abort_s = tmo_expired_s && !m_axil_rvalid;
            default: abort_s = 1'b0;
        endcase
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            araddr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else if (abort_s) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            araddr_q      <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b10;
            rsp_timeout_q <= 1'b1;
            state_q       <= RSP;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        if (cmd_rnw) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= cmd_addr;
                            state_q   <= RD_ADDR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            state_q   <= WR;
                        end
                    end
                end
                WR: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    if (awvalid_q && m_axil_awready) begin
                        awvalid_q <= 1'b0;
                        awaddr_q  <= '0;
                    end
                    if (wvalid_q && m_axil_wready) begin
                        wvalid_q <= 1'b0;
                        wdata_q  <= '0;
                    end
                    // Each channel is done once it was accepted earlier or is accepted now.
                    if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= m_axil_bresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RSP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                RD_ADDR: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        araddr_q  <= '0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axil_rvalid) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= m_axil_rdata;
                        rsp_resp_q    <= m_axil_rresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RSP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= 2'b00;
                        rsp_timeout_q <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = {(DATA_WIDTH/8){1'b1}};
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_ctrl.sv
// Directed plus randomized bench for axil_master_ctrl; a cycle-level slave model
// drives the AXI side and expected results come from delay arithmetic.
module tb_axil_master_ctrl;

    localparam int TMO = 16;

    logic        core_clk = 1'b0;
    logic        core_reset;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks   = 0;
    int failures = 0;

    axil_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .core_clk(core_clk), .core_reset(core_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    endtask

    // One command through a slave with the given wait counts; starts and ends at a negedge.
    task automatic run_txn(input string tag, input logic rnw, input logic [31:0] addr,
                           input logic [31:0] wval, input logic [31:0] rval, input logic [1:0] resp_v,
                           input int awd, input int wd, input int ard, input int dd, input int rspd);
        int done_edge, exp_lat, lat, bad, bad_rsp;
        int aw_cycles, w_cycles, ar_cycles, aw_beats, w_beats, ar_beats, bwait, rwait;
        bit to, aw_done, w_done, ar_done, b_done, r_done, p_aw, p_w, p_ar, p_b, p_r;
        logic [1:0]  exp_resp, hold_resp;
        logic [31:0] exp_data, hold_data;
        logic        hold_to;
        lat = 0; bad = 0; bad_rsp = 0;
        aw_cycles = 0; w_cycles = 0; ar_cycles = 0; aw_beats = 0; w_beats = 0; ar_beats = 0;
        bwait = 0; rwait = 0;
        aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0;

        // Reference: edge (after accept) at which the response handshake would happen.
        if (rnw) done_edge = ard + 1 + 2 + dd;
        else     done_edge = ((awd > wd) ? awd : wd) + 1 + 2 + dd;
        to       = (done_edge > TMO);
        exp_lat  = to ? TMO + 1 : done_edge + 1;
        exp_resp = to ? 2'b10 : resp_v;
        exp_data = (to || !rnw) ? 32'h0 : rval;

        check({tag, ":cmd_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wval;
        @(posedge core_clk);
        #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;

        for (int n = 1; n <= 40; n++) begin
            @(negedge core_clk);
            if (p_aw) aw_done = 1;
            if (p_w)  w_done  = 1;
            if (p_ar) ar_done = 1;
            if (p_b)  b_done  = 1;
            if (p_r)  r_done  = 1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
            if (cmd_ready) bad++;
            if (awvalid) begin aw_cycles++; if (awaddr !== addr) bad++; end
            else if (awaddr !== 32'h0) bad++;
            if (wvalid) begin w_cycles++; if (wdata !== wval) bad++; end
            else if (wdata !== 32'h0) bad++;
            if (arvalid) begin ar_cycles++; if (araddr !== addr) bad++; end
            else if (araddr !== 32'h0) bad++;
            if (rnw && (awvalid || wvalid || bready)) bad++;
            if (!rnw && (arvalid || rready)) bad++;

            awready = awvalid && (aw_cycles > awd);
            wready  = wvalid && (w_cycles > wd);
            arready = arvalid && (ar_cycles > ard);
            if (!rnw && aw_done && w_done && !b_done) begin
                bvalid = (bwait > dd); bwait++;
            end else begin
                bvalid = rnw ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (rnw && ar_done && !r_done) begin
                rvalid = (rwait > dd); rwait++;
            end else begin
                rvalid = rnw ? 1'b0 : 1'($urandom_range(0, 1));
            end
            bresp = resp_v; rresp = resp_v; rdata = rval;
            p_aw = awvalid && awready;  aw_beats += int'(p_aw);
            p_w  = wvalid && wready;    w_beats  += int'(p_w);
            p_ar = arvalid && arready;  ar_beats += int'(p_ar);
            p_b  = !rnw && bvalid && bready;
            p_r  = rnw && rvalid && rready;
        end
        idle_slave();

        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":resp"}, rsp_resp, exp_resp);
        check({tag, ":rdata"}, rsp_rdata, exp_data);
        check({tag, ":timeout"}, rsp_timeout, to);
        check({tag, ":channel_rules"}, bad, 0);
        if (to) begin
            check({tag, ":axi_quiet"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        end else if (rnw) begin
            check({tag, ":ar_beats"}, ar_beats, 1);
            check({tag, ":ar_cycles"}, ar_cycles, ard + 1);
        end else begin
            check({tag, ":aw_w_beats"}, {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
            check({tag, ":aw_w_cycles"}, {aw_cycles[7:0], w_cycles[7:0]}, {8'(awd + 1), 8'(wd + 1)});
        end

        hold_data = rsp_rdata; hold_resp = rsp_resp; hold_to = rsp_timeout;
        rsp_ready = 1'b0;
        for (int k = 0; k < rspd; k++) begin
            @(negedge core_clk);
            if (!rsp_valid || rsp_rdata !== hold_data || rsp_resp !== hold_resp ||
                rsp_timeout !== hold_to || cmd_ready) bad_rsp++;
        end
        check({tag, ":rsp_hold"}, bad_rsp, 0);
        rsp_ready = 1'b1;
        @(posedge core_clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge core_clk);
        check({tag, ":rsp_done"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        logic        r_rnw;
        logic [31:0] r_addr, r_wd, r_rd;
        logic [1:0]  r_resp;

        core_reset = 1'b1;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        idle_slave();
        #1;
        check("rst_ctl", {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, awvalid, wvalid, bready, arvalid, rready}, 10'h0);
        check("rst_data", rsp_rdata | awaddr | wdata | araddr, 32'h0);
        repeat (2) @(posedge core_clk);
        #1;
        check("rst_hold", {cmd_ready, rsp_valid, awvalid, arvalid}, 4'h0);
        @(negedge core_clk);
        core_reset = 1'b0;
        @(posedge core_clk);
        #1;
        check("rst_release_cmd_ready", cmd_ready, 1'b1);
        check("const_prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
        @(negedge core_clk);

        run_txn("wr_zero_wait", 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 0, 0, 0, 0, 0);
        run_txn("rd_wait3", 1'b1, 32'h14, 32'h0, 32'h12345678, 2'b00, 0, 0, 0, 3, 1);
        run_txn("wr_aw_late", 1'b0, 32'h20, 32'hA5A5_0001, 32'h0, 2'b01, 5, 0, 0, 1, 0);
        run_txn("wr_w_late", 1'b0, 32'h24, 32'h0BAD_F00D, 32'h0, 2'b00, 0, 4, 0, 0, 0);
        run_txn("rd_no_arready", 1'b1, 32'h30, 32'h0, 32'hFFFF_FFFF, 2'b00, 0, 0, 100, 0, 0);
        run_txn("rd_rsp_stall", 1'b1, 32'h34, 32'h0, 32'hCAFE_0042, 2'b11, 0, 0, 1, 0, 10);
        run_txn("wr_edge_ok", 1'b0, 32'h40, 32'h1111_2222, 32'h0, 2'b00, 0, 0, 0, 13, 0);
        run_txn("wr_edge_tmo", 1'b0, 32'h44, 32'h3333_4444, 32'h0, 2'b00, 0, 0, 0, 14, 0);
        run_txn("rd_edge_ok", 1'b1, 32'h48, 32'h0, 32'h5555_6666, 2'b10, 0, 0, 13, 0, 0);

        // Reset pulse while the write address channel is stalled.
        check("pre_rst_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h50; cmd_wdata = 32'h7777_8888;
        @(posedge core_clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge core_clk);
        check("pre_rst_awvalid", {awvalid, bready}, 2'b10);
        #2;
        core_reset = 1'b1;
        #1;
        check("mid_rst_drop", {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid}, 7'h0);
        @(posedge core_clk);
        #1;
        check("mid_rst_no_rsp", {rsp_valid, rsp_timeout, awvalid}, 3'b0);
        @(negedge core_clk);
        core_reset = 1'b0;
        @(posedge core_clk);
        #1;
        check("post_rst_ready", {cmd_ready, rsp_valid}, 2'b10);
        @(negedge core_clk);
        run_txn("wr_after_rst", 1'b0, 32'h54, 32'h9999_AAAA, 32'h0, 2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            r_rnw  = 1'($urandom_range(0, 1));
            r_addr = {$urandom_range(0, 1023), 2'b00};
            r_wd   = $urandom;
            r_rd   = $urandom;
            r_resp = 2'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", i), r_rnw, r_addr, r_wd, r_rd, r_resp,
                    $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 12),
                    $urandom_range(0, 9), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
